// File: rtl/tranconv_fmap_responder.sv
// Feature-map RAM responder: host load -> accelerator run -> host drain -> done pulse.
// Accelerator reads have 1-cycle latency; drain stream is valid/ready with a one-entry skid.
module tranconv_fmap_responder #(
    parameter int AW = 15,
    parameter int DW = 12
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:0] input_rsc_radr,
    input  logic          input_rsc_re,
    output logic [DW-1:0] input_rsc_q,
    input  logic          input_triosy_lz,
    input  logic [AW-1:0] output_rsc_wadr,
    input  logic [DW-1:0] output_rsc_d,
    input  logic          output_rsc_we,
    input  logic [AW-1:0] output_rsc_radr,
    input  logic          output_rsc_re,
    output logic [DW-1:0] output_rsc_q,
    input  logic          output_triosy_lz,
    input  logic          start,
    input  logic [AW:0]   load_words,
    input  logic [AW:0]   drain_words,
    input  logic          ld_valid,
    output logic          ld_ready,
    input  logic [DW-1:0] ld_data,
    output logic          dr_valid,
    input  logic          dr_ready,
    output logic [DW-1:0] dr_data,
    output logic          busy,
    output logic          done,
    output logic [2:0]    state_o,
    output logic          acc_err
);
    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_LOAD  = 3'd1,
        S_RUN   = 3'd2,
        S_DRAIN = 3'd3,
        S_DONE  = 3'd4
    } state_t;

    localparam logic [AW:0] FULL = {1'b1, {AW{1'b0}}};
    localparam logic [AW:0] ONE  = {{AW{1'b0}}, 1'b1};

    logic [DW-1:0] r_in_mem  [0:(1<<AW)-1];
    logic [DW-1:0] r_out_mem [0:(1<<AW)-1];

    state_t        r_state, w_nxt;
    logic [AW:0]   r_load_words, r_drain_words;
    logic [AW:0]   r_ld_cnt, r_dr_radr, r_dr_cnt;
    logic          r_in_lat, r_out_lat, r_acc_err;
    logic          r_rd_vld, r_sk_vld;
    logic [DW-1:0] r_rd_dat, r_sk_dat, r_in_q, r_out_q;

    logic          w_run, w_start, w_ld_beat, w_ld_last, w_in_fin, w_out_fin;
    logic          w_pop, w_sk_take, w_issue, w_dr_last, w_viol;
    logic [AW:0]   w_lw, w_dw;

    assign w_run     = (r_state == S_RUN);
    assign w_start   = (r_state == S_IDLE) && start;
    assign w_lw      = (load_words > FULL) ? FULL : load_words;
    assign w_dw      = (drain_words > FULL) ? FULL : drain_words;
    assign w_ld_beat = (r_state == S_LOAD) && ld_valid;
    assign w_ld_last = w_ld_beat && ((r_ld_cnt + ONE) == r_load_words);
    assign w_in_fin  = r_in_lat | input_triosy_lz;
    assign w_out_fin = r_out_lat | output_triosy_lz;

    // Two-deep drain pipe: RAM read register feeds the skid register that drives dr_*.
    assign w_pop     = r_sk_vld && dr_ready;
    assign w_sk_take = r_rd_vld && (!r_sk_vld || w_pop);
    assign w_issue   = (r_state == S_DRAIN) && (r_dr_radr < r_drain_words)
                       && (!r_rd_vld || w_sk_take);
    assign w_dr_last = w_pop && ((r_dr_cnt + ONE) == r_drain_words);
    assign w_viol    = !w_run && (input_rsc_re || output_rsc_re || output_rsc_we
                                  || input_triosy_lz || output_triosy_lz);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nxt;
    end

    always_comb begin
        w_nxt    = r_state;
        ld_ready = 1'b0;
        done     = 1'b0;
        busy     = (r_state != S_IDLE);
        case (r_state)
            S_IDLE:  if (start) w_nxt = (w_lw == '0) ? S_RUN : S_LOAD;
            S_LOAD: begin
                ld_ready = 1'b1;
                if (w_ld_last) w_nxt = S_RUN;
            end
            S_RUN:   if (w_in_fin && w_out_fin)
                         w_nxt = (r_drain_words == '0) ? S_DONE : S_DRAIN;
            S_DRAIN: if (w_dr_last) w_nxt = S_DONE;
            S_DONE: begin
                done  = 1'b1;
                w_nxt = S_IDLE;
            end
            default: w_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_load_words  <= '0;
            r_drain_words <= '0;
            r_ld_cnt      <= '0;
            r_dr_radr     <= '0;
            r_dr_cnt      <= '0;
            r_in_lat      <= 1'b0;
            r_out_lat     <= 1'b0;
            r_acc_err     <= 1'b0;
            r_rd_vld      <= 1'b0;
            r_sk_vld      <= 1'b0;
            r_sk_dat      <= '0;
            r_in_q        <= '0;
            r_out_q       <= '0;
        end else begin
            if (w_start) begin
                r_load_words  <= w_lw;
                r_drain_words <= w_dw;
                r_ld_cnt      <= '0;
                r_dr_radr     <= '0;
                r_dr_cnt      <= '0;
                r_in_lat      <= 1'b0;
                r_out_lat     <= 1'b0;
                r_acc_err     <= 1'b0;
            end
            // An illegal access in the start cycle still counts against the new job.
            if (w_viol) r_acc_err <= 1'b1;
            if (w_ld_beat) r_ld_cnt <= r_ld_cnt + ONE;
            if (w_run && input_triosy_lz)  r_in_lat  <= 1'b1;
            if (w_run && output_triosy_lz) r_out_lat <= 1'b1;
            if (w_run && input_rsc_re)  r_in_q  <= r_in_mem[input_rsc_radr];
            if (w_run && output_rsc_re) r_out_q <= r_out_mem[output_rsc_radr];
            if (w_issue) r_dr_radr <= r_dr_radr + ONE;
            if (w_issue)        r_rd_vld <= 1'b1;
            else if (w_sk_take) r_rd_vld <= 1'b0;
            if (w_sk_take) begin
                r_sk_vld <= 1'b1;
                r_sk_dat <= r_rd_dat;
            end else if (w_pop) begin
                r_sk_vld <= 1'b0;
            end
            if (w_pop) r_dr_cnt <= r_dr_cnt + ONE;
        end
    end

    always_ff @(posedge clk) begin
        if (w_ld_beat) r_in_mem[r_ld_cnt[AW-1:0]] <= ld_data;
        if (w_run && output_rsc_we) r_out_mem[output_rsc_wadr] <= output_rsc_d;
        if (w_issue) r_rd_dat <= r_out_mem[r_dr_radr[AW-1:0]];
    end

    assign input_rsc_q  = r_in_q;
    assign output_rsc_q = r_out_q;
    assign dr_valid     = r_sk_vld;
    assign dr_data      = r_sk_dat;
    assign state_o      = r_state;
    assign acc_err      = r_acc_err;
endmodule

// File: tb/tb_tranconv_fmap_responder.sv
// Directed bench for tranconv_fmap_responder: job phases, drain flow control, RAM hazards, errors, reset.
module tb_tranconv_fmap_responder;
    localparam int AW = 15;
    localparam int DW = 12;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [AW-1:0] input_rsc_radr = '0;
    logic          input_rsc_re = 1'b0;
    logic [DW-1:0] input_rsc_q;
    logic          input_triosy_lz = 1'b0;
    logic [AW-1:0] output_rsc_wadr = '0;
    logic [DW-1:0] output_rsc_d = '0;
    logic          output_rsc_we = 1'b0;
    logic [AW-1:0] output_rsc_radr = '0;
    logic          output_rsc_re = 1'b0;
    logic [DW-1:0] output_rsc_q;
    logic          output_triosy_lz = 1'b0;
    logic          start = 1'b0;
    logic [AW:0]   load_words = '0;
    logic [AW:0]   drain_words = '0;
    logic          ld_valid = 1'b0;
    logic          ld_ready;
    logic [DW-1:0] ld_data = '0;
    logic          dr_valid;
    logic          dr_ready = 1'b0;
    logic [DW-1:0] dr_data;
    logic          busy;
    logic          done;
    logic [2:0]    state_o;
    logic          acc_err;

    int n_checks = 0;
    int n_fail   = 0;

    tranconv_fmap_responder #(.AW(AW), .DW(DW)) dut (
        .clk(clk), .rst(rst),
        .input_rsc_radr(input_rsc_radr), .input_rsc_re(input_rsc_re), .input_rsc_q(input_rsc_q),
        .input_triosy_lz(input_triosy_lz),
        .output_rsc_wadr(output_rsc_wadr), .output_rsc_d(output_rsc_d), .output_rsc_we(output_rsc_we),
        .output_rsc_radr(output_rsc_radr), .output_rsc_re(output_rsc_re), .output_rsc_q(output_rsc_q),
        .output_triosy_lz(output_triosy_lz),
        .start(start), .load_words(load_words), .drain_words(drain_words),
        .ld_valid(ld_valid), .ld_ready(ld_ready), .ld_data(ld_data),
        .dr_valid(dr_valid), .dr_ready(dr_ready), .dr_data(dr_data),
        .busy(busy), .done(done), .state_o(state_o), .acc_err(acc_err)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic start_job(input int lw, input int dw);
        load_words  = (AW+1)'(lw);
        drain_words = (AW+1)'(dw);
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    task automatic finish_run();
        input_triosy_lz  = 1'b1;
        output_triosy_lz = 1'b1;
        step();
        input_triosy_lz  = 1'b0;
        output_triosy_lz = 1'b0;
    endtask

    task automatic test_reset();
        #1 rst = 1'b1;
        step();
        step();
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL reset_state: got %0d want 0", state_o); end
        n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", busy); end
        n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", done); end
        n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL reset_ld_ready: got %b want 0", ld_ready); end
        n_checks++; if (dr_valid !== 1'b0) begin n_fail++; $display("FAIL reset_dr_valid: got %b want 0", dr_valid); end
        n_checks++; if (dr_data !== 12'h000) begin n_fail++; $display("FAIL reset_dr_data: got %h want 000", dr_data); end
        n_checks++; if (acc_err !== 1'b0) begin n_fail++; $display("FAIL reset_acc_err: got %b want 0", acc_err); end
        n_checks++; if (input_rsc_q !== 12'h000) begin n_fail++; $display("FAIL reset_in_q: got %h want 000", input_rsc_q); end
        n_checks++; if (output_rsc_q !== 12'h000) begin n_fail++; $display("FAIL reset_out_q: got %h want 000", output_rsc_q); end
        rst = 1'b0;
        step();
    endtask

    task automatic test_basic_job();
        start_job(4, 4);
        n_checks++; if (state_o !== 3'd1) begin n_fail++; $display("FAIL basic_load_state: got %0d want 1", state_o); end
        n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy: got %b want 1", busy); end
        n_checks++; if (ld_ready !== 1'b1) begin n_fail++; $display("FAIL basic_ld_ready: got %b want 1", ld_ready); end
        for (int i = 0; i < 4; i++) begin
            ld_valid = 1'b1;
            ld_data  = 12'(i + 1);
            step();
        end
        ld_valid = 1'b0;
        n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL basic_run_state: got %0d want 2", state_o); end
        n_checks++; if (ld_ready !== 1'b0) begin n_fail++; $display("FAIL basic_ld_ready_drop: got %b want 0", ld_ready); end
        for (int a = 0; a < 4; a++) begin
            input_rsc_re   = 1'b1;
            input_rsc_radr = AW'(a);
            step();
            input_rsc_re = 1'b0;
            n_checks++;
            if (input_rsc_q !== 12'(a + 1)) begin
                n_fail++; $display("FAIL basic_in_read[%0d]: got %h want %h", a, input_rsc_q, 12'(a + 1));
            end
            output_rsc_we   = 1'b1;
            output_rsc_wadr = AW'(a);
            output_rsc_d    = input_rsc_q + 12'h100;
            step();
            output_rsc_we = 1'b0;
        end
        input_triosy_lz = 1'b1;
        step();
        input_triosy_lz = 1'b0;
        step();
        n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL basic_wait_run: got %0d want 2", state_o); end
        output_triosy_lz = 1'b1;
        step();
        output_triosy_lz = 1'b0;
        dr_ready = 1'b1;
        n_checks++; if (state_o !== 3'd3) begin n_fail++; $display("FAIL basic_drain_state: got %0d want 3", state_o); end
        n_checks++; if (dr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_dv_d0: got %b want 0", dr_valid); end
        step();
        n_checks++; if (dr_valid !== 1'b0) begin n_fail++; $display("FAIL basic_dv_d1: got %b want 0", dr_valid); end
        step();
        for (int k = 0; k < 4; k++) begin
            n_checks++;
            if (dr_valid !== 1'b1 || dr_data !== 12'(12'h101 + k)) begin
                n_fail++; $display("FAIL basic_beat[%0d]: got v=%b d=%h want v=1 d=%h", k, dr_valid, dr_data, 12'(12'h101 + k));
            end
            step();
        end
        n_checks++; if (done !== 1'b1 || state_o !== 3'd4) begin n_fail++; $display("FAIL basic_done: got done=%b st=%0d want 1/4", done, state_o); end
        step();
        n_checks++; if (done !== 1'b0 || state_o !== 3'd0) begin n_fail++; $display("FAIL basic_idle: got done=%b st=%0d want 0/0", done, state_o); end
        n_checks++; if (acc_err !== 1'b0) begin n_fail++; $display("FAIL basic_acc_err: got %b want 0", acc_err); end
    endtask

    task automatic test_protocol_error();
        output_rsc_we   = 1'b1;
        output_rsc_wadr = '0;
        output_rsc_d    = 12'hFFF;
        step();
        output_rsc_we = 1'b0;
        n_checks++; if (acc_err !== 1'b1) begin n_fail++; $display("FAIL perr_set: got %b want 1", acc_err); end
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL perr_state: got %0d want 0", state_o); end
        start_job(0, 1);
        n_checks++; if (acc_err !== 1'b0) begin n_fail++; $display("FAIL perr_clear: got %b want 0", acc_err); end
        n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL perr_run: got %0d want 2", state_o); end
        finish_run();
        dr_ready = 1'b1;
        for (int i = 0; i < 10; i++) begin
            if (dr_valid) break;
            step();
        end
        n_checks++;
        if (dr_valid !== 1'b1 || dr_data !== 12'h101) begin
            n_fail++; $display("FAIL perr_ram_intact: got v=%b d=%h want v=1 d=101", dr_valid, dr_data);
        end
        step();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL perr_done: got %b want 1", done); end
        step();
    endtask

    task automatic test_back_to_back();
        int pat [4] = '{1, 0, 0, 1};
        int got;
        logic stall;
        logic [DW-1:0] prev;
        got = 0;
        stall = 1'b0;
        prev = '0;
        start_job(0, 8);
        for (int i = 0; i < 8; i++) begin
            output_rsc_we   = 1'b1;
            output_rsc_wadr = AW'(i);
            output_rsc_d    = 12'(12'h200 + i);
            step();
        end
        output_rsc_we = 1'b0;
        finish_run();
        for (int cyc = 0; cyc < 60 && got < 8; cyc++) begin
            dr_ready = pat[cyc % 4][0];
            if (stall) begin
                n_checks++;
                if (dr_valid !== 1'b1 || dr_data !== prev) begin
                    n_fail++; $display("FAIL bp_stable c%0d: got v=%b d=%h want v=1 d=%h", cyc, dr_valid, dr_data, prev);
                end
            end
            if (dr_valid && dr_ready) begin
                n_checks++;
                if (dr_data !== 12'(12'h200 + got)) begin
                    n_fail++; $display("FAIL bp_beat[%0d]: got %h want %h", got, dr_data, 12'(12'h200 + got));
                end
                got++;
            end
            stall = dr_valid && !dr_ready;
            prev  = dr_data;
            step();
        end
        n_checks++; if (got != 8) begin n_fail++; $display("FAIL bp_count: got %0d want 8", got); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL bp_done: got %b want 1", done); end
        dr_ready = 1'b1;
        step();
    endtask

    task automatic test_zero_length();
        start_job(0, 0);
        n_checks++; if (state_o !== 3'd2) begin n_fail++; $display("FAIL zero_run: got %0d want 2", state_o); end
        finish_run();
        n_checks++; if (state_o !== 3'd4 || done !== 1'b1) begin n_fail++; $display("FAIL zero_done: got st=%0d done=%b want 4/1", state_o, done); end
        step();
        n_checks++; if (state_o !== 3'd0 || done !== 1'b0) begin n_fail++; $display("FAIL zero_idle: got st=%0d done=%b want 0/0", state_o, done); end
        n_checks++; if (acc_err !== 1'b0) begin n_fail++; $display("FAIL zero_acc_err: got %b want 0", acc_err); end
    endtask

    task automatic test_read_first();
        start_job(0, 0);
        output_rsc_we   = 1'b1;
        output_rsc_wadr = AW'(5);
        output_rsc_d    = 12'hAAA;
        step();
        output_rsc_d    = 12'h555;
        output_rsc_re   = 1'b1;
        output_rsc_radr = AW'(5);
        step();
        output_rsc_we = 1'b0;
        n_checks++; if (output_rsc_q !== 12'hAAA) begin n_fail++; $display("FAIL rf_old: got %h want aaa", output_rsc_q); end
        step();
        output_rsc_re = 1'b0;
        n_checks++; if (output_rsc_q !== 12'h555) begin n_fail++; $display("FAIL rf_new: got %h want 555", output_rsc_q); end
        finish_run();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rf_done: got %b want 1", done); end
        step();
    endtask

    task automatic test_reset_mid_drain();
        int got;
        got = 0;
        start_job(0, 8);
        finish_run();
        dr_ready = 1'b1;
        for (int cyc = 0; cyc < 30; cyc++) begin
            if (got == 3) break;
            if (dr_valid && dr_ready) got++;
            step();
        end
        n_checks++; if (got != 3) begin n_fail++; $display("FAIL rmd_pre_beats: got %0d want 3", got); end
        rst = 1'b1;
        #1;
        n_checks++; if (dr_valid !== 1'b0) begin n_fail++; $display("FAIL rmd_dv: got %b want 0", dr_valid); end
        n_checks++; if (state_o !== 3'd0) begin n_fail++; $display("FAIL rmd_state: got %0d want 0", state_o); end
        step();
        rst = 1'b0;
        step();
        start_job(0, 2);
        finish_run();
        got = 0;
        for (int cyc = 0; cyc < 30 && got < 2; cyc++) begin
            if (dr_valid && dr_ready) begin
                n_checks++;
                if (dr_data !== 12'(12'h200 + got)) begin
                    n_fail++; $display("FAIL rmd_new[%0d]: got %h want %h", got, dr_data, 12'(12'h200 + got));
                end
                got++;
            end
            step();
        end
        n_checks++; if (got != 2) begin n_fail++; $display("FAIL rmd_new_count: got %0d want 2", got); end
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL rmd_done: got %b want 1", done); end
        step();
    endtask

    initial begin
        test_reset();
        test_basic_job();
        test_protocol_error();
        test_back_to_back();
        test_zero_length();
        test_read_first();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
